// File: rtl/rstcon_pkg.sv
// Shared definitions for the rstcon reset controller: FSM encodings, cause codes
// and the parameter-legality check used at elaboration.
package rstcon_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } rstcon_state_e;

    localparam logic [1:0] CAUSE_POR = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    function automatic bit rstcon_params_ok(input int unsigned sync_stages,
                                            input int unsigned n_ch,
                                            input int unsigned stretch_cyc,
                                            input int unsigned ch_gap);
        return (sync_stages >= 2) && (n_ch >= 1) && (n_ch <= 16) &&
               (stretch_cyc >= 1) && (ch_gap >= 1);
    endfunction

endpackage

// File: rtl/rstcon_sync_chain.sv
// Reset synchroniser: asserts immediately on rst_async, releases rst_sync
// after STAGES rising edges of clk.
module rstcon_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_async,
    output logic rst_sync
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = sync_q[STAGES-1];

endmodule

// File: rtl/rstcon_seq.sv
// Multi-channel reset sequencer: stretched, index-ordered channel release plus
// CSR software reset. Define RSTCON_CAUSE_EN to add the rst_cause output.
module rstcon_seq
    import rstcon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned N_CH        = 4,
    parameter int unsigned STRETCH_CYC = 16,
    parameter int unsigned CH_GAP      = 8
) (
    input  logic            clk,
    input  logic            rst_async,
    input  logic            sw_rst_req,
    input  logic [N_CH-1:0] sw_rst_ch,
    output logic [N_CH-1:0] rst_out,
    output logic            rst_done,
    output logic            busy
`ifdef RSTCON_CAUSE_EN
    ,
    output logic [1:0]      rst_cause
`endif
);

    localparam int unsigned CNT_MAX = (STRETCH_CYC > CH_GAP) ? STRETCH_CYC : CH_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    if (!rstcon_params_ok(SYNC_STAGES, N_CH, STRETCH_CYC, CH_GAP)) begin : g_param_err
        $error("rstcon_seq: illegal parameter set");
    end

    rstcon_state_e    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_CH-1:0]  pend_nxt;
    logic [N_CH-1:0]  pend_rel;
    logic             rst_sync;
    logic             stretch_step;
    logic             release_one;

    rstcon_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_async (rst_async),
        .rst_sync  (rst_sync)
    );

    // rst_out doubles as the pending mask; releasing clears its lowest set bit
    assign pend_rel = rst_out & (rst_out - N_CH'(1));

    // The edge where rst_sync drops is T0, so HOLD with rst_sync low is already the first stretch step
    assign stretch_step = (state == ST_STRETCH) || ((state == ST_HOLD) && !rst_sync);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_nxt    = rst_out;
        release_one = 1'b0;
        case (state)
            ST_HOLD, ST_STRETCH: begin
                if (stretch_step) begin
                    if (cnt == CNT_W'(STRETCH_CYC - 1)) begin
                        release_one = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + CNT_W'(1);
                        state_nxt = ST_STRETCH;
                    end
                end
            end
            ST_RELEASE: begin
                if (cnt == CNT_W'(CH_GAP - 1)) begin
                    release_one = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (sw_rst_req && (sw_rst_ch != '0)) begin
                    pend_nxt  = sw_rst_ch;
                    cnt_nxt   = '0;
                    state_nxt = ST_STRETCH;
                end
            end
            default: state_nxt = ST_HOLD;
        endcase
        if (release_one) begin
            pend_nxt  = pend_rel;
            cnt_nxt   = '0;
            state_nxt = (pend_rel == '0) ? ST_RUN : ST_RELEASE;
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            rst_out  <= '1;
            rst_done <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rst_out  <= pend_nxt;
            rst_done <= (state_nxt == ST_RUN);
            busy     <= (state_nxt != ST_RUN);
        end
    end

`ifdef RSTCON_CAUSE_EN
    // Cause is latched on the edge a software sequence starts
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            rst_cause <= CAUSE_POR;
        end else if ((state == ST_RUN) && sw_rst_req && (sw_rst_ch != '0)) begin
            rst_cause <= CAUSE_SW;
        end
    end
`endif

endmodule
